multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max wait cycles in IF/MEM_L/MEM_S before abort; 0 disables timeout.
REQ-002 Parameter TMO_W, default 8, wait-counter width; SHALL satisfy MEM_TIMEOUT < 2**TMO_W.
REQ-003 Parameter HAS_MDU, default 1, enables multicycle mul/div execute state.
REQ-004 Parameter CNT_W, default 32, retired-instruction counter width.
REQ-005 Port list (one clock; reset asynchronous, active-low):
- clk  in  1  sole clock, rising edge
- rstn  in  1  asynchronous active-low reset
- op  in  6  instruction opcode
- funct  in  6  R-type function field
- mem_ready  in  1  memory completes current access this cycle
- mdu_done  in  1  mul/div unit result valid
- IF_signal, ID_signal, EX_signal, MEM_signal, WB_signal  out  1 each  phase strobes
- IorD_signal  out  1  memory address from data path (1) or PC (0)
- IRWr  out  1  instruction register write enable
- mdu_start  out  1  one-cycle mul/div launch
- instr_done  out  1  one-cycle retire pulse
- illegal_op  out  1  one-cycle undecodable-instruction pulse
- mem_timeout  out  1  one-cycle memory-abort pulse
- state  out  4  current state code
- instret  out  CNT_W  retired-instruction count

Function
REQ-006 States: INI, IF, ID, EX_RI, EX_LS, EX_BRANCH, EX_JUMP, EX_MDU, MEM_L, MEM_S, WB_R, WB_L; state register only sequential control element besides counters.
REQ-007 INI -> IF unconditionally after one cycle.
REQ-008 IF holds until mem_ready=1, then -> ID; IRWr = (state==IF) & mem_ready.
REQ-009 ID decode: op 0x00 with funct JR(0x08)/JALR(0x09) -> EX_JUMP; funct 0x18-0x1B -> EX_MDU if HAS_MDU else INI+illegal_op; other R-type -> EX_RI; op 0x08-0x0F -> EX_RI; op 0x01,0x04-0x07 -> EX_BRANCH; op 0x02,0x03 -> EX_JUMP; op 0x20,0x21,0x23,0x24,0x25,0x28,0x29,0x2B -> EX_LS; else -> INI with illegal_op=1 one cycle.
REQ-010 EX_LS -> MEM_L for loads, MEM_S for stores.
REQ-011 EX_RI -> WB_R; EX_MDU holds until mdu_done=1, then -> WB_R; mdu_start=1 only on first EX_MDU cycle.
REQ-012 MEM_L holds until mem_ready, then -> WB_L; MEM_S holds until mem_ready, then -> IF.
REQ-013 EX_BRANCH, EX_JUMP, WB_R, WB_L -> IF.
REQ-014 Strobes Moore-decoded from state: IF_signal in IF; ID_signal in ID; EX_signal in any EX_*; MEM_signal in MEM_L/MEM_S; WB_signal in WB_R/WB_L; IorD_signal in MEM_L/MEM_S.
REQ-015 instr_done=1 on final cycle of an instruction: EX_BRANCH, EX_JUMP, WB_R, WB_L, and MEM_S with mem_ready=1; instret increments by 1 same edge, wraps modulo 2**CNT_W.
REQ-016 Wait counter clears on entering IF/MEM_L/MEM_S, increments each waiting cycle with mem_ready=0; when MEM_TIMEOUT!=0 and counter reaches MEM_TIMEOUT-1 with mem_ready=0, next state INI and mem_timeout=1 one cycle.
REQ-017 mem_ready=1 in the expiry cycle wins: normal transition, no mem_timeout.
REQ-018 mem_ready/mdu_done outside wait states ignored; op/funct sampled only in ID (and EX_LS).
REQ-019 With mem_ready tied 1: branch/jump 3 cycles, R/I-ALU and store 4, load 5, IF-to-IF.

Reset
REQ-020 rstn=0 asynchronously forces state=INI, wait counter=0, instret=0, all 1-bit outputs 0; effective mid-instruction with no retire.
REQ-021 First rising edge after rstn deasserts moves INI -> IF.

Structure
REQ-022 State codes (4-bit), opcode and funct constants SHALL live in shared header ctrl_encode_def.v, extended with EX_MDU and I-type ALU opcodes.
REQ-023 Wait counter with timeout compare SHALL be sub-module mem_wait_timer (clk, rstn, clear, inc, expired).

Verification
REQ-024 Reset then mem_ready=1, op=0x23 (LW): states INI,IF,ID,EX_LS,MEM_L,WB_L,IF; IRWr 1 cycle; IorD_signal 1 in MEM_L; instret=1.
REQ-025 op=0x00 funct=0x20, then op=0x04, then op=0x02: 4,3,3 cycles; instr_done three pulses; instret=3.
REQ-026 op=0x00 funct=0x18, mdu_done raised 5 cycles after EX_MDU entry: mdu_start single pulse, EX_MDU held 6 cycles, then WB_R, IF.
REQ-027 mem_ready=0 in IF, MEM_TIMEOUT=16: mem_timeout pulses after 16th IF cycle, next state INI; repeat with mem_ready=1 on 16th cycle: ID, no pulse.
REQ-028 op=0x3F: ID -> INI, illegal_op one pulse, instret unchanged.
REQ-029 rstn pulsed low during MEM_L: immediately state=INI, outputs 0, instret=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcode/funct
// constants and the ID-stage instruction decoder.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_INI       = 4'd0,
      S_IF        = 4'd1,
      S_ID        = 4'd2,
      S_EX_RI     = 4'd3,
      S_EX_LS     = 4'd4,
      S_EX_BRANCH = 4'd5,
      S_EX_JUMP   = 4'd6,
      S_EX_MDU    = 4'd7,
      S_MEM_L     = 4'd8,
      S_MEM_S     = 4'd9,
      S_WB_R      = 4'd10,
      S_WB_L      = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BLTZ  = 6'h01;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FUNCT_JR   = 6'h08;
   localparam logic [5:0] FUNCT_JALR = 6'h09;

   // Returns S_INI for anything undecodable; the caller flags illegal_op on that.
   function automatic state_t decode_id(input logic [5:0] op,
                                        input logic [5:0] funct,
                                        input logic       has_mdu);
      state_t nxt;
      nxt = S_INI;
      if (op == OP_RTYPE) begin
         if (funct == FUNCT_JR || funct == FUNCT_JALR) nxt = S_EX_JUMP;
         else if (funct[5:2] == 4'b0110)               nxt = has_mdu ? S_EX_MDU : S_INI;
         else                                          nxt = S_EX_RI;
      end else if (op[5:3] == 3'b001) begin
         nxt = S_EX_RI;
      end else if (op == OP_BLTZ || op[5:2] == 4'b0001) begin
         nxt = S_EX_BRANCH;
      end else if (op == OP_J || op == OP_JAL) begin
         nxt = S_EX_JUMP;
      end else begin
         case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: nxt = S_EX_LS;
            default:                                                  nxt = S_INI;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter shared by the memory wait states and the mul/div wait;
// flags the last permitted memory wait cycle.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TMO_W       = 8
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic inc,
   output logic expired,
   output logic at_zero
);

   localparam logic [TMO_W-1:0] LAST = (MEM_TIMEOUT == 0) ? '0 : TMO_W'(MEM_TIMEOUT - 1);

   logic [TMO_W-1:0] cnt;

   // Saturates so a disabled timeout or a long mul/div never wraps back to zero.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                    cnt <= '0;
      else if (clear)               cnt <= '0;
      else if (inc && (cnt != '1))  cnt <= cnt + 1'b1;
   end

   assign expired = (MEM_TIMEOUT != 0) && (cnt == LAST);
   assign at_zero = (cnt == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: fetch/decode/execute/memory/writeback
// sequencing with memory-wait timeout, mul/div handshake and retire counter.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TMO_W       = 8,
   parameter int HAS_MDU     = 1,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   input  logic             mdu_done,
   output logic             IF_signal,
   output logic             ID_signal,
   output logic             EX_signal,
   output logic             MEM_signal,
   output logic             WB_signal,
   output logic             IorD_signal,
   output logic             IRWr,
   output logic             mdu_start,
   output logic             instr_done,
   output logic             illegal_op,
   output logic             mem_timeout,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instret
);

   state_t state_q, state_d;
   logic   w_inc, w_clear, w_expired, w_at_zero;

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(TMO_W)) u_wait (
      .clk     (clk),
      .rstn    (rstn),
      .clear   (w_clear),
      .inc     (w_inc),
      .expired (w_expired),
      .at_zero (w_at_zero)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_INI;
         instret <= '0;
      end else begin
         state_q <= state_d;
         if (instr_done) instret <= instret + 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      IRWr        = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
      w_inc       = 1'b0;
      case (state_q)
         S_INI: state_d = S_IF;
         S_IF: begin
            if (mem_ready) begin
               state_d = S_ID;
               IRWr    = 1'b1;
            end else if (w_expired) begin
               state_d     = S_INI;
               mem_timeout = 1'b1;
            end else begin
               w_inc = 1'b1;
            end
         end
         S_ID: begin
            state_d    = decode_id(op, funct, HAS_MDU != 0);
            illegal_op = (state_d == S_INI);
         end
         // Store opcodes all have op[3] set; loads never do.
         S_EX_LS: state_d = op[3] ? S_MEM_S : S_MEM_L;
         S_EX_RI: state_d = S_WB_R;
         S_EX_MDU: begin
            if (mdu_done) state_d = S_WB_R;
            else          w_inc   = 1'b1;
         end
         S_MEM_L, S_MEM_S: begin
            if (mem_ready) begin
               state_d    = (state_q == S_MEM_S) ? S_IF : S_WB_L;
               instr_done = (state_q == S_MEM_S);
            end else if (w_expired) begin
               state_d     = S_INI;
               mem_timeout = 1'b1;
            end else begin
               w_inc = 1'b1;
            end
         end
         S_EX_BRANCH, S_EX_JUMP, S_WB_R, S_WB_L: begin
            state_d    = S_IF;
            instr_done = 1'b1;
         end
         default: state_d = S_INI;
      endcase
   end

   // Any state change restarts the wait count, so each wait state starts at zero.
   assign w_clear = (state_d != state_q);

   assign mdu_start   = (HAS_MDU != 0) && (state_q == S_EX_MDU) && w_at_zero;
   assign IF_signal   = (state_q == S_IF);
   assign ID_signal   = (state_q == S_ID);
   assign EX_signal   = (state_q == S_EX_RI) || (state_q == S_EX_LS) || (state_q == S_EX_BRANCH) ||
                        (state_q == S_EX_JUMP) || (state_q == S_EX_MDU);
   assign MEM_signal  = (state_q == S_MEM_L) || (state_q == S_MEM_S);
   assign WB_signal   = (state_q == S_WB_R) || (state_q == S_WB_L);
   assign IorD_signal = MEM_signal;
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected records are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_multicycle_ctrl;

   localparam logic [3:0] INI = 4'd0,  IFS = 4'd1,  IDS = 4'd2,  RI  = 4'd3,
                          LS  = 4'd4,  BR  = 4'd5,  JMP = 4'd6,  MDU = 4'd7,
                          ML  = 4'd8,  MS  = 4'd9,  WBR = 4'd10, WBL = 4'd11;
   localparam logic [4:0] P0 = 5'b00000, P_IR = 5'b10000, P_MS = 5'b01000,
                          P_DN = 5'b00100, P_IL = 5'b00010, P_TO = 5'b00001;

   typedef struct {
      logic [3:0]  st;
      logic [4:0]  pul;
      logic [31:0] ir;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic [5:0]  op, funct;
   logic        mem_ready, mdu_done;
   logic        IF_signal, ID_signal, EX_signal, MEM_signal, WB_signal, IorD_signal;
   logic        IRWr, mdu_start, instr_done, illegal_op, mem_timeout;
   logic [3:0]  state;
   logic [31:0] instret;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_instret = 0;

   multicycle_ctrl #(.MEM_TIMEOUT(16), .TMO_W(8), .HAS_MDU(1), .CNT_W(32)) dut (
      .clk(clk), .rstn(rstn), .op(op), .funct(funct),
      .mem_ready(mem_ready), .mdu_done(mdu_done),
      .IF_signal(IF_signal), .ID_signal(ID_signal), .EX_signal(EX_signal),
      .MEM_signal(MEM_signal), .WB_signal(WB_signal), .IorD_signal(IorD_signal),
      .IRWr(IRWr), .mdu_start(mdu_start), .instr_done(instr_done),
      .illegal_op(illegal_op), .mem_timeout(mem_timeout),
      .state(state), .instret(instret)
   );

   always #5 clk = ~clk;

   // Expected {IF,ID,EX,MEM,WB,IorD} for a given state code.
   function automatic logic [5:0] strobes(input logic [3:0] st);
      logic [5:0] s;
      s = 6'b0;
      case (st)
         IFS:                    s = 6'b100000;
         IDS:                    s = 6'b010000;
         RI, LS, BR, JMP, MDU:   s = 6'b001000;
         ML, MS:                 s = 6'b000101;
         WBR, WBL:               s = 6'b000010;
         default:                s = 6'b000000;
      endcase
      return s;
   endfunction

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t       e;
         logic [5:0] act_s;
         logic [4:0] act_p;
         e     = sb.pop_front();
         act_s = {IF_signal, ID_signal, EX_signal, MEM_signal, WB_signal, IorD_signal};
         act_p = {IRWr, mdu_start, instr_done, illegal_op, mem_timeout};
         n_vec++;
         if (state !== e.st || act_s !== strobes(e.st) || act_p !== e.pul || instret !== e.ir) begin
            n_err++;
            $display("FAIL vec%0d: got state=%0d strobes=%b pulses=%b instret=%0d, want state=%0d strobes=%b pulses=%b instret=%0d",
                     n_vec, state, act_s, act_p, instret, e.st, strobes(e.st), e.pul, e.ir);
         end
      end
   end

   // One clock cycle: drive inputs, queue the expected outputs, advance.
   task automatic cyc(input logic [3:0] st, input logic rdy, input logic md, input logic [4:0] pul);
      exp_t e;
      mem_ready = rdy;
      mdu_done  = md;
      e.st  = st;
      e.pul = pul;
      e.ir  = exp_instret;
      sb.push_back(e);
      if (pul[2]) exp_instret = exp_instret + 1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0; op = 6'h00; funct = 6'h00; mem_ready = 1'b0; mdu_done = 1'b0;
      @(posedge clk); #1;
      cyc(INI, 0, 0, P0);
      rstn = 1'b1;
      cyc(INI, 1, 0, P0);

      op = 6'h23;                         // lw
      cyc(IFS, 1, 0, P_IR); cyc(IDS, 1, 0, P0); cyc(LS, 1, 0, P0);
      cyc(ML, 1, 0, P0);    cyc(WBL, 1, 0, P_DN);
      op = 6'h00; funct = 6'h20;          // add
      cyc(IFS, 1, 0, P_IR); cyc(IDS, 1, 0, P0); cyc(RI, 1, 0, P0); cyc(WBR, 1, 0, P_DN);
      op = 6'h04;                         // beq
      cyc(IFS, 1, 0, P_IR); cyc(IDS, 1, 0, P0); cyc(BR, 1, 0, P_DN);
      op = 6'h02;                         // j
      cyc(IFS, 1, 0, P_IR); cyc(IDS, 1, 0, P0); cyc(JMP, 1, 0, P_DN);
      op = 6'h0C;                         // andi
      cyc(IFS, 1, 0, P_IR); cyc(IDS, 1, 0, P0); cyc(RI, 1, 0, P0); cyc(WBR, 1, 0, P_DN);
      op = 6'h2B;                         // sw
      cyc(IFS, 1, 0, P_IR); cyc(IDS, 1, 0, P0); cyc(LS, 1, 0, P0); cyc(MS, 1, 0, P_DN);
      op = 6'h20;                         // lb with two memory wait cycles
      cyc(IFS, 1, 0, P_IR); cyc(IDS, 1, 0, P0); cyc(LS, 1, 0, P0);
      cyc(ML, 0, 0, P0); cyc(ML, 0, 0, P0); cyc(ML, 1, 0, P0); cyc(WBL, 1, 0, P_DN);
      op = 6'h00; funct = 6'h18;          // mult, done 5 cycles after entry
      cyc(IFS, 1, 0, P_IR); cyc(IDS, 1, 0, P0); cyc(MDU, 1, 0, P_MS);
      for (int i = 0; i < 4; i++) cyc(MDU, 1, 0, P0);
      cyc(MDU, 1, 1, P0); cyc(WBR, 1, 0, P_DN);
      funct = 6'h08;                      // jr
      cyc(IFS, 1, 0, P_IR); cyc(IDS, 1, 0, P0); cyc(JMP, 1, 0, P_DN);
      op = 6'h3F;                         // undecodable
      cyc(IFS, 1, 0, P_IR); cyc(IDS, 1, 0, P_IL); cyc(INI, 1, 0, P0);

      for (int i = 0; i < 15; i++) cyc(IFS, 0, 0, P0);
      cyc(IFS, 0, 0, P_TO); cyc(INI, 0, 0, P0);
      for (int i = 0; i < 15; i++) cyc(IFS, 0, 0, P0);
      cyc(IFS, 1, 0, P_IR); cyc(IDS, 1, 0, P_IL); cyc(INI, 1, 0, P0);

      op = 6'h23;                         // reset lands mid-load
      cyc(IFS, 1, 0, P_IR); cyc(IDS, 1, 0, P0); cyc(LS, 1, 0, P0); cyc(ML, 0, 0, P0);
      rstn = 1'b0;
      exp_instret = 0;
      #1;
      cyc(INI, 1, 0, P0);
      rstn = 1'b1;
      cyc(INI, 1, 0, P0);
      op = 6'h02;
      cyc(IFS, 1, 0, P_IR); cyc(IDS, 1, 0, P0); cyc(JMP, 1, 0, P_DN);
      cyc(IFS, 0, 0, P0);

      @(negedge clk); #1;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d records left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
